// File: rtl/cmd_buffer_sched.sv
// Command buffer controller: host packets land in RAM at their symbol ID, and a
// start pulse streams the occupied entries to the rasteriser in ascending address order.
module cmd_buffer_sched #(
    parameter int BUFFER_PKT_BITS    = 32,
    parameter int NUM_BUF_ELEMS_BITS = 4
) (
    input  logic                          i_clk,
    input  logic                          n_btn_rst,
    input  logic                          in_valid,
    input  logic [BUFFER_PKT_BITS-1:0]    in_data,
    output logic                          in_ready,
    input  logic                          clear,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_BUF_ELEMS_BITS:0]   entry_count,
    output logic                          out_valid,
    output logic [BUFFER_PKT_BITS-1:0]    out_data,
    output logic [NUM_BUF_ELEMS_BITS-1:0] out_addr,
    input  logic                          out_ready,
    output logic                          buf_we,
    output logic [NUM_BUF_ELEMS_BITS-1:0] buf_waddr,
    output logic [BUFFER_PKT_BITS-1:0]    buf_wdata,
    output logic                          buf_re,
    output logic [NUM_BUF_ELEMS_BITS-1:0] buf_raddr,
    input  logic [BUFFER_PKT_BITS-1:0]    buf_rdata
);

    localparam int DEPTH = 1 << NUM_BUF_ELEMS_BITS;
    localparam int CW    = NUM_BUF_ELEMS_BITS + 1;
    localparam logic [NUM_BUF_ELEMS_BITS-1:0] LAST_ADDR = {NUM_BUF_ELEMS_BITS{1'b1}};
    localparam logic [NUM_BUF_ELEMS_BITS-1:0] ADDR_ONE  = NUM_BUF_ELEMS_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_BUF_ELEMS_BITS-1:0]   scan_addr_q, scan_addr_d;
    logic [DEPTH-1:0]                bitmap_q, bitmap_d;
    logic [CW-1:0]                   count_q, count_d;
    logic                            in_ready_q;
    logic                            wr_s;
    logic                            buf_re_s;

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign wr_s      = in_valid && in_ready_q;
    assign buf_we    = wr_s;
    assign buf_waddr = in_data[NUM_BUF_ELEMS_BITS-1:0];
    assign buf_wdata = in_data;
    assign buf_re    = buf_re_s;
    assign buf_raddr = scan_addr_q;

    // The RAM keeps its read register while buf_re is low, so data is taken straight from it.
    assign in_ready    = in_ready_q;
    assign busy        = (state_q == S_SCAN) || (state_q == S_PRESENT);
    assign done        = (state_q == S_DONE);
    assign out_valid   = (state_q == S_PRESENT);
    assign out_data    = buf_rdata;
    assign out_addr    = scan_addr_q;
    assign entry_count = count_q;

    // Occupancy: clear wipes first so a same-cycle write still leaves its entry valid.
    always_comb begin
        bitmap_d = bitmap_q;
        if (clear) begin
            bitmap_d = '0;
        end else begin
            bitmap_d = bitmap_q;
        end
        if (wr_s) begin
            bitmap_d[in_data[NUM_BUF_ELEMS_BITS-1:0]] = 1'b1;
        end else begin
            bitmap_d = bitmap_d;
        end
        count_d = popcount(bitmap_d);
    end

    // Scan FSM next-state and read strobe.
    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        buf_re_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SCAN;
                    scan_addr_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (bitmap_q[scan_addr_q]) begin
                    buf_re_s = 1'b1;
                    state_d  = S_PRESENT;
                end else if (scan_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    scan_addr_d = scan_addr_q + ADDR_ONE;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (scan_addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_SCAN;
                        scan_addr_d = scan_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, occupancy and handshake registers.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            state_q     <= S_IDLE;
            scan_addr_q <= '0;
            bitmap_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            bitmap_q    <= bitmap_d;
            count_q     <= count_d;
            in_ready_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_buffer_sched.sv
// Bench for cmd_buffer_sched: behavioural RAM, occupancy/data reference model,
// directed scenarios plus randomized write/scan rounds with random back-pressure.
module tb_cmd_buffer_sched;

    localparam int PW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          i_clk = 1'b0;
    logic          n_btn_rst;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic          clear;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW:0]   entry_count;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_ready;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [PW-1:0] buf_wdata;
    logic          buf_re;
    logic [AW-1:0] buf_raddr;
    logic [PW-1:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bit            mvalid[DEPTH];
    logic [PW-1:0] mdata[DEPTH];
    logic [PW-1:0] mem[DEPTH];

    cmd_buffer_sched #(.BUFFER_PKT_BITS(PW), .NUM_BUF_ELEMS_BITS(AW)) dut (
        .i_clk(i_clk), .n_btn_rst(n_btn_rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clear(clear), .start(start), .busy(busy), .done(done),
        .entry_count(entry_count),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(ram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Command RAM: read-before-write, registered read held while buf_re is low.
    always @(posedge i_clk) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        if (buf_re) ram_rdata <= mem[buf_raddr];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mvalid[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    endtask

    task automatic write_pkt(input logic [AW-1:0] id, input logic [PW-1:0] payload);
        logic [PW-1:0] d;
        d = payload;
        d[AW-1:0] = id;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        mvalid[id] = 1'b1;
        mdata[id]  = d;
        n_checks++;
        if (int'(entry_count) !== model_count()) begin
            n_fail++;
            $display("FAIL write_count: id=%0d entry_count=%0d expected %0d", id, entry_count, model_count());
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        n_checks++;
        if (entry_count !== 5'd0) begin
            n_fail++;
            $display("FAIL clear_count: entry_count=%0d expected 0", entry_count);
        end
    endtask

    task automatic wait_present(input int exp_addr);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (!out_valid || out_addr !== AW'(exp_addr) || out_data !== mdata[exp_addr]) begin
            n_fail++;
            $display("FAIL present: valid=%0b addr=%0d data=%h expected addr=%0d data=%h",
                     out_valid, out_addr, out_data, exp_addr, mdata[exp_addr]);
        end
    endtask

    // Runs until done with out_ready low; no packet may be offered on the way.
    task automatic wait_done_no_stream();
        int n = 0;
        int nvalid = 0;
        bit seen = 1'b0;
        out_ready = 1'b0;
        while (!seen && n < 60) begin
            if (out_valid) nvalid++;
            if (done) seen = 1'b1;
            tick();
            n++;
        end
        n_checks++;
        if (!seen || nvalid != 0) begin
            n_fail++;
            $display("FAIL tail_done: done_seen=%0b extra_valid_cycles=%0d expected 1/0", seen, nvalid);
        end
    endtask

    task automatic do_scan(input int ready_pct, output int first_valid, output int done_cycle,
                           output int last_hs);
        int exp_q[$];
        int cyc, nre, nexp, a;
        bit stalled;
        logic [PW-1:0] st_data;
        logic [AW-1:0] st_addr;
        for (int i = 0; i < DEPTH; i++) if (mvalid[i]) exp_q.push_back(i);
        nexp = exp_q.size();
        first_valid = -1; done_cycle = -1; last_hs = -1; nre = 0; stalled = 1'b0;
        st_data = '0; st_addr = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done_cycle < 0 && cyc < 300) begin
            if (buf_re) nre++;
            if (done) done_cycle = cyc;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled) begin
                    n_checks++;
                    if (out_data !== st_data || out_addr !== st_addr) begin
                        n_fail++;
                        $display("FAIL stall_hold: addr=%0d data=%h expected addr=%0d data=%h",
                                 out_addr, out_data, st_addr, st_data);
                    end
                end
                if (out_ready) begin
                    stalled = 1'b0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL stream_extra: addr=%0d data=%h expected no packet", out_addr, out_data);
                    end else begin
                        a = exp_q.pop_front();
                        if (out_addr !== AW'(a) || out_data !== mdata[a]) begin
                            n_fail++;
                            $display("FAIL stream_pkt: addr=%0d data=%h expected addr=%0d data=%h",
                                     out_addr, out_data, a, mdata[a]);
                        end
                    end
                    last_hs = cyc;
                end else begin
                    stalled = 1'b1;
                    st_data = out_data;
                    st_addr = out_addr;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (done_cycle < 0 || exp_q.size() != 0 || nre != nexp) begin
            n_fail++;
            $display("FAIL scan_end: done_cycle=%0d missing=%0d buf_re_pulses=%0d expected done/0/%0d",
                     done_cycle, exp_q.size(), nre, nexp);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: busy=%0b done=%0b expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset();
        n_btn_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
            entry_count !== 5'd0 || out_addr !== 4'd0 || buf_we !== 1'b0 || buf_re !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b busy=%0b done=%0b ov=%0b cnt=%0d addr=%0d expected all 0",
                     in_ready, busy, done, out_valid, entry_count, out_addr);
        end
        @(negedge i_clk);
        n_btn_rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_pre_edge: in_ready=%0b expected 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_rise: in_ready=%0b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int fv, dc, lh;
        write_pkt(4'd3, $urandom());
        write_pkt(4'd7, $urandom());
        write_pkt(4'd15, $urandom());
        do_scan(100, fv, dc, lh);
        n_checks++;
        if (dc != lh + 1 || entry_count !== 5'd3) begin
            n_fail++;
            $display("FAIL basic_done: done_cycle=%0d last_hs=%0d cnt=%0d expected %0d/3", dc, lh, entry_count, lh + 1);
        end
    endtask

    task automatic test_rewrite();
        int fv, dc, lh;
        do_clear();
        write_pkt(4'd5, 32'h0000_AA05);
        write_pkt(4'd5, 32'h0000_BB05);
        do_scan(100, fv, dc, lh);
    endtask

    task automatic test_backpressure();
        int fv, dc, lh;
        do_clear();
        write_pkt(4'd0, $urandom());
        write_pkt(4'd1, $urandom());
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 4'd0 || out_data !== mdata[0] ||
                busy !== 1'b1 || buf_re !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: ov=%0b addr=%0d data=%h busy=%0b re=%0b expected 1/0/%h/1/0",
                         k, out_valid, out_addr, out_data, busy, buf_re, mdata[0]);
            end
            if (k < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_present(1);
        out_ready = 1'b1;
        tick();
        wait_done_no_stream();
    endtask

    task automatic test_empty();
        int fv, dc, lh;
        do_clear();
        do_scan(100, fv, dc, lh);
        n_checks++;
        if (fv != -1 || dc != 17) begin
            n_fail++;
            $display("FAIL empty_scan: first_valid=%0d done_cycle=%0d expected -1/17", fv, dc);
        end
    endtask

    task automatic test_latency();
        int fv, dc, lh;
        do_clear();
        write_pkt(4'd0, $urandom());
        do_scan(100, fv, dc, lh);
        n_checks++;
        if (fv != 2) begin
            n_fail++;
            $display("FAIL latency: first_valid=%0d expected 2", fv);
        end
    endtask

    task automatic test_write_during_scan();
        int fv, dc, lh;
        do_clear();
        write_pkt(4'd4, $urandom());
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_present(4);
        write_pkt(4'd12, $urandom());
        write_pkt(4'd2, $urandom());
        wait_present(4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_present(12);
        out_ready = 1'b1;
        tick();
        wait_done_no_stream();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = {$urandom_range(0, 65535), 12'h0, 4'd9};
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        mvalid[9] = 1'b1;
        mdata[9]  = in_data;
        n_checks++;
        if (entry_count !== 5'd1) begin
            n_fail++;
            $display("FAIL clear_write: entry_count=%0d expected 1", entry_count);
        end
        do_scan(100, fv, dc, lh);
    endtask

    task automatic test_clear_during_scan();
        do_clear();
        write_pkt(4'd2, $urandom());
        write_pkt(4'd6, $urandom());
        write_pkt(4'd10, $urandom());
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_present(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        wait_present(2);
        n_checks++;
        if (entry_count !== 5'd0) begin
            n_fail++;
            $display("FAIL clear_mid: entry_count=%0d expected 0", entry_count);
        end
        out_ready = 1'b1;
        tick();
        wait_done_no_stream();
    endtask

    task automatic test_reset_mid_scan();
        int fv, dc, lh;
        do_clear();
        write_pkt(4'd5, $urandom());
        write_pkt(4'd11, $urandom());
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_present(5);
        #2;
        n_btn_rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
            entry_count !== 5'd0 || out_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%0b busy=%0b done=%0b ov=%0b cnt=%0d addr=%0d expected all 0",
                     in_ready, busy, done, out_valid, entry_count, out_addr);
        end
        model_clear();
        @(negedge i_clk);
        n_btn_rst = 1'b1;
        tick();
        do_scan(100, fv, dc, lh);
        n_checks++;
        if (fv != -1 || dc != 17) begin
            n_fail++;
            $display("FAIL post_reset_scan: first_valid=%0d done_cycle=%0d expected -1/17", fv, dc);
        end
    endtask

    task automatic test_random();
        int fv, dc, lh, nw;
        for (int r = 0; r < 8; r++) begin
            if (r % 3 == 1) do_clear();
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) write_pkt(AW'($urandom_range(0, DEPTH - 1)), $urandom());
            do_scan(60, fv, dc, lh);
            n_checks++;
            if (int'(entry_count) !== model_count()) begin
                n_fail++;
                $display("FAIL rand_count: round=%0d entry_count=%0d expected %0d", r, entry_count, model_count());
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; clear = 1'b0; start = 1'b0; out_ready = 1'b0;
        ram_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0; mdata[i] = '0; mvalid[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_rewrite();
        test_backpressure();
        test_empty();
        test_latency();
        test_write_during_scan();
        test_clear_during_scan();
        test_reset_mid_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_buffer_sched.md
Name: cmd_buffer_sched

Overview:
- Controller that owns both ports of the command buffer RAM (1-cycle registered read, write-enable/read-enable, element-addressed).
- Write side: accepts command packets from the host link. Each packet is stored at the address carried in its byte 0 (symbol ID).
- Read side: on a start pulse, walks the buffer in ascending address order and streams only the occupied entries to the rasteriser through a valid/ready handshake.
- Tracks occupancy with a per-entry valid bitmap and a live entry count.

Parameters:
- BUFFER_PKT_BITS, 32, width of one packet/buffer element; must be >= 8.
- NUM_BUF_ELEMS_BITS, 4, address width; buffer depth = 2^NUM_BUF_ELEMS_BITS; must be <= 8.

Ports:
- i_clk  in  1  clock
- n_btn_rst  in  1  asynchronous active-low reset
- in_valid  in  1  host packet valid
- in_data  in  BUFFER_PKT_BITS  host packet; bits [NUM_BUF_ELEMS_BITS-1:0] are the write address
- in_ready  out  1  packet accepted when in_valid && in_ready
- clear  in  1  one-cycle pulse; invalidates all entries
- start  in  1  one-cycle pulse; begins a scan
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- entry_count  out  NUM_BUF_ELEMS_BITS+1  number of valid entries
- out_valid  out  1  streamed packet valid
- out_data  out  BUFFER_PKT_BITS  streamed packet
- out_addr  out  NUM_BUF_ELEMS_BITS  address of the streamed packet
- out_ready  in  1  consumer accept
- buf_we  out  1  RAM write enable
- buf_waddr  out  NUM_BUF_ELEMS_BITS  RAM write address
- buf_wdata  out  BUFFER_PKT_BITS  RAM write data
- buf_re  out  1  RAM read enable
- buf_raddr  out  NUM_BUF_ELEMS_BITS  RAM read address
- buf_rdata  in  BUFFER_PKT_BITS  RAM read data, valid the cycle after buf_re

Behaviour:
- Reset (asynchronous, active-low): in_ready=0, busy=0, done=0, out_valid=0, entry_count=0, out_addr=0, bitmap all 0, state=IDLE. in_ready rises to 1 on the first clock after reset release.
- Reset asserted mid-scan aborts immediately. No done pulse. RAM contents are not cleared, but the bitmap is.
- Write path: combinational pass-through.
  - buf_we = in_valid && in_ready.
  - buf_waddr = in_data[NUM_BUF_ELEMS_BITS-1:0].
  - buf_wdata = in_data.
  - An accepted write sets the bitmap bit. A rewrite of an already-valid address overwrites the data; entry_count is unchanged.
- in_ready stays 1 in all states, including during a scan.
- clear zeroes the bitmap and entry_count next cycle.
  - clear and an accepted write in the same cycle: the written entry ends valid and entry_count=1.
- entry_count is always equal to the popcount of the bitmap, updated in the same cycle as the bitmap.
- Scan FSM:
  - IDLE: busy=0. start moves to SCAN with scan_addr=0. start is ignored when not in IDLE.
  - SCAN: busy=1.
    - If bitmap[scan_addr]=1: buf_re=1, buf_raddr=scan_addr, go to PRESENT.
    - Else, if scan_addr is the last address, go to DONE; otherwise scan_addr+1 and stay in SCAN.
    - Throughput: one address per cycle.
  - PRESENT:
    - out_valid=1; out_data=buf_rdata (RAM holds it because buf_re stays 0); out_addr=scan_addr.
    - out_data and out_addr hold stable until handshake.
    - On out_valid && out_ready: if scan_addr is the last address, go to DONE; otherwise scan_addr+1 and go to SCAN.
  - DONE: done=1 for exactly one cycle, then IDLE.
- buf_re is asserted only in SCAN, for exactly one cycle per valid entry.
- Latency: a valid entry at address 0 gives out_valid two cycles after the start pulse.
- scan_addr wrap: the scan terminates at the last address; it never wraps.
- Write during scan:
  - To an address already passed: stored, not streamed this scan.
  - To an address not yet reached: streamed with the new data.
  - To the same address as the SCAN read in that cycle: the RAM returns the old data.
- clear during scan: an entry in PRESENT still completes; the remaining entries are skipped; done still pulses.
- Empty buffer scan: 2^NUM_BUF_ELEMS_BITS SCAN cycles, then done; out_valid never asserts.

Test Plan:
- Write packets with symbol IDs 3, 7, 15 (defaults), then start with out_ready=1 → stream at addrs 3, 7, 15 with matching data; done 1 cycle after the last handshake; entry_count=3.
- Write ID 5 twice (0xAA05, then 0xBB05), then start → exactly one packet, 0xBB05; entry_count=1.
- Entries at addrs 0 and 1, out_ready held 0 for 4 cycles → out_valid, out_data, out_addr stable at addr 0 for 4 cycles; busy=1; no buf_re pulses.
- Empty buffer, start → done exactly 17 cycles after start (16 SCAN cycles + DONE); out_valid never 1.
- During a scan, write ID 12 while presenting addr 4 and write ID 2 → ID 12 is streamed, ID 2 is not; clear and write ID 9 in the same cycle → entry_count=1.
- Reset pulse while in PRESENT → all outputs return to their reset values asynchronously; a following start with an empty bitmap streams nothing.
